keypad_scanner: RTL and testbench

// Drives the column strobes of a 4x4 matrix keypad and samples its row lines.

---
 rtl/keypad_pkg.sv | 50 +++++
 rtl/keypad_scanner_sync_2ff.sv | 29 ++
 rtl/keypad_scanner.sv | 164 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states, key map,
// idle column pattern and small row/column decode helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Result of looking for exactly one low row line
    typedef struct packed {
        logic       hit;
        logic [1:0] row;
    } row_hit_t;

    localparam logic [3:0] IDLE_COLS = 4'b1111;

    // Key codes, rows top->bottom, columns left->right
    localparam logic [3:0] KEYMAP [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Exactly one low row is a key; none or several (ghosting) is not
    function automatic row_hit_t find_low_row(input logic [3:0] rows);
        row_hit_t res;
        res.hit = 1'b1;
        res.row = 2'd0;
        case (rows)
            4'b1110: res.row = 2'd0;
            4'b1101: res.row = 2'd1;
            4'b1011: res.row = 2'd2;
            4'b0111: res.row = 2'd3;
            default: res.hit = 1'b0;
        endcase
        return res;
    endfunction

    // Active-low one-hot strobe / row pattern for an index
    function automatic logic [3:0] low_onehot(input logic [1:0] idx);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, with a configurable
// reset value so idle (pulled-up) lines do not look active after reset.
module sync_2ff #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes columns, samples synchronized rows,
// debounces press and release, and emits one key code pulse per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 24000,
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [3:0] rows_s;
    row_hit_t   hit_s;

    state_t           state_r,     state_s;
    logic [1:0]       col_r,       col_s;
    logic [CNT_W-1:0] cnt_r,       cnt_s;
    logic [1:0]       cap_row_r,   cap_row_s;
    logic [3:0]       key_code_r,  key_code_s;
    logic             key_valid_r, key_valid_s;
    logic             key_held_r,  key_held_s;
    logic [3:0]       col_n_r,     col_n_s;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (IDLE_COLS)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_n),
        .q     (rows_s)
    );

    assign hit_s = find_low_row(rows_s);

    // Next-state, counter, capture and output computation
    always_comb begin
        state_s     = state_r;
        col_s       = col_r;
        cnt_s       = cnt_r;
        cap_row_s   = cap_row_r;
        key_code_s  = key_code_r;
        key_valid_s = 1'b0;
        key_held_s  = 1'b0;
        col_n_s     = IDLE_COLS;

        if (!en) begin
            state_s = SCAN;
            col_s   = 2'd0;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                SCAN: begin
                    if (col_n_r == IDLE_COLS) begin
                        // Columns not yet driven: start the dwell once the strobe is out
                        cnt_s = CNT_ZERO;
                    end else if (cnt_r == SCAN_LAST) begin
                        cnt_s = CNT_ZERO;
                        if (hit_s.hit) begin
                            cap_row_s = hit_s.row;
                            state_s   = DEBOUNCE;
                        end else begin
                            col_s = col_r + 2'd1;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (rows_s == low_onehot(cap_row_r)) begin
                        if (cnt_r == DEB_LAST) begin
                            cnt_s       = CNT_ZERO;
                            state_s     = HELD;
                            key_valid_s = 1'b1;
                            key_code_s  = KEYMAP[cap_row_r][col_r];
                        end else begin
                            cnt_s = cnt_r + CNT_ONE;
                        end
                    end else begin
                        // Bounce: retry the same column with a fresh dwell
                        state_s = SCAN;
                        cnt_s   = CNT_ZERO;
                    end
                end
                HELD: begin
                    cnt_s = CNT_ZERO;
                    if (rows_s[cap_row_r]) begin
                        state_s = RELEASE;
                    end else begin
                        state_s = HELD;
                    end
                end
                RELEASE: begin
                    if (rows_s[cap_row_r]) begin
                        if (cnt_r == DEB_LAST) begin
                            state_s = SCAN;
                            cnt_s   = CNT_ZERO;
                            col_s   = col_r + 2'd1;
                        end else begin
                            cnt_s = cnt_r + CNT_ONE;
                        end
                    end else begin
                        state_s = HELD;
                        cnt_s   = CNT_ZERO;
                    end
                end
                default: begin
                    state_s = SCAN;
                    col_s   = 2'd0;
                    cnt_s   = CNT_ZERO;
                end
            endcase

            col_n_s = low_onehot(col_s);
            if ((state_s == HELD) || (state_s == RELEASE)) begin
                key_held_s = 1'b1;
            end else begin
                key_held_s = 1'b0;
            end
        end
    end

    // State, counter and registered output update
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= SCAN;
            col_r       <= 2'd0;
            cnt_r       <= CNT_ZERO;
            cap_row_r   <= 2'd0;
            key_code_r  <= 4'h0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
            col_n_r     <= IDLE_COLS;
        end else begin
            state_r     <= state_s;
            col_r       <= col_s;
            cnt_r       <= cnt_s;
            cap_row_r   <= cap_row_s;
            key_code_r  <= key_code_s;
            key_valid_r <= key_valid_s;
            key_held_r  <= key_held_s;
            col_n_r     <= col_n_s;
        end
    end

    assign col_n     = col_n_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a matrix keypad model and a
// scoreboard of expected key codes.
module tb_keypad_scanner;

    localparam int SCAN_CYCLES     = 4;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam int CNT_W           = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys;
    logic [3:0]  exp_q [$];
    int errors    = 0;
    int checks    = 0;
    int pulse_cnt = 0;

    keypad_scanner #(
        .SCAN_CYCLES     (SCAN_CYCLES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key shorts its row to its column strobe
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c]) row_n[r] = row_n[r] & col_n[c];
            end
        end
    end

    // Scoreboard: every pulse must match the oldest expected key code
    always @(negedge clk) begin
        if (reset === 1'b1 && key_valid === 1'b1) begin
            pulse_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: key_code=%h with no press pending", key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key_code !== e) begin
                    errors++;
                    $display("FAIL pulse_code: got %h expected %h", key_code, e);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pulse(input string name, output int waited);
        waited = 0;
        while (key_valid !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        checks++;
        if (key_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: no key_valid after %0d cycles", name, waited);
        end
    endtask

    task automatic release_all(input string name);
        int n;
        keys = 16'h0000;
        n = 0;
        while (key_held !== 1'b0 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (key_held !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: key_held=%b expected 0", name, key_held);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        logic [3:0] one;
        logic [3:0] e;
        one   = 4'b0001;
        keys  = 16'h0000;
        en    = 1'b1;
        reset = 1'b0;
        repeat (3) tick();
        checks += 4;
        if (col_n !== 4'b1111) begin errors++; $display("FAIL reset_col_n: got %b expected 1111", col_n); end
        if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b expected 0", key_valid); end
        if (key_held !== 1'b0) begin errors++; $display("FAIL reset_key_held: got %b expected 0", key_held); end
        if (key_code !== 4'h0) begin errors++; $display("FAIL reset_key_code: got %h expected 0", key_code); end
        reset = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            e = ~(one << ((i / 4) % 4));
            checks++;
            if (col_n !== e) begin
                errors++;
                $display("FAIL scan_seq[%0d]: col_n=%b expected %b", i, col_n, e);
            end
            tick();
        end
    endtask

    task automatic test_steady_press();
        int w;
        int p0;
        keys[1*4+1] = 1'b1;
        exp_q.push_back(4'h5);
        wait_pulse("steady", w);
        checks += 2;
        if (key_code !== 4'h5) begin errors++; $display("FAIL steady_code: got %h expected 5", key_code); end
        if (key_held !== 1'b1) begin errors++; $display("FAIL steady_held: got %b expected 1", key_held); end
        p0 = pulse_cnt;
        repeat (100) tick();
        checks += 2;
        if (pulse_cnt !== p0) begin errors++; $display("FAIL steady_repeat: pulses=%0d expected %0d", pulse_cnt, p0); end
        if (key_held !== 1'b1) begin errors++; $display("FAIL steady_still_held: got %b expected 1", key_held); end
        release_all("steady");
    endtask

    task automatic test_bounce_press();
        int w;
        int p0;
        p0 = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            keys[2*4+2] = (i % 2 == 0);
            repeat (3) tick();
        end
        checks++;
        if (pulse_cnt !== p0) begin errors++; $display("FAIL bounce_no_pulse: pulses=%0d expected %0d", pulse_cnt, p0); end
        keys[2*4+2] = 1'b1;
        exp_q.push_back(4'h9);
        wait_pulse("bounce", w);
        checks += 2;
        if (w < DEBOUNCE_CYCLES) begin errors++; $display("FAIL bounce_latency: pulse after %0d cycles, need >= %0d", w, DEBOUNCE_CYCLES); end
        if (key_code !== 4'h9) begin errors++; $display("FAIL bounce_code: got %h expected 9", key_code); end
        p0 = pulse_cnt;
        repeat (20) tick();
        checks++;
        if (pulse_cnt !== p0) begin errors++; $display("FAIL bounce_single: pulses=%0d expected %0d", pulse_cnt, p0); end
        release_all("bounce");
    endtask

    task automatic test_release_bounce();
        int w;
        int p0;
        int n;
        keys[1*4+1] = 1'b1;
        exp_q.push_back(4'h5);
        wait_pulse("relb", w);
        repeat (4) tick();
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            keys[1*4+1] = (i % 2 == 1);
            tick();
            checks++;
            if (key_held !== 1'b1) begin errors++; $display("FAIL relb_held_bounce[%0d]: got %b expected 1", i, key_held); end
        end
        keys[1*4+1] = 1'b1;
        repeat (6) tick();
        checks += 2;
        if (key_held !== 1'b1) begin errors++; $display("FAIL relb_held_after: got %b expected 1", key_held); end
        if (pulse_cnt !== p0) begin errors++; $display("FAIL relb_no_pulse: pulses=%0d expected %0d", pulse_cnt, p0); end
        keys = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (key_held !== 1'b1) begin errors++; $display("FAIL relb_held_clean[%0d]: got %b expected 1", i, key_held); end
        end
        n = 0;
        while (key_held !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        checks += 2;
        if (key_held !== 1'b0) begin errors++; $display("FAIL relb_drop: key_held=%b expected 0", key_held); end
        if (col_n !== 4'b1011) begin errors++; $display("FAIL relb_resume_col: col_n=%b expected 1011", col_n); end
        repeat (4) tick();
    endtask

    task automatic test_ghost_then_d();
        int w;
        int p0;
        p0 = pulse_cnt;
        keys[0*4+0] = 1'b1;
        keys[2*4+0] = 1'b1;
        repeat (40) tick();
        checks++;
        if (pulse_cnt !== p0) begin errors++; $display("FAIL ghost_no_pulse: pulses=%0d expected %0d", pulse_cnt, p0); end
        keys = 16'h0000;
        repeat (4) tick();
        keys[3*4+3] = 1'b1;
        exp_q.push_back(4'hD);
        wait_pulse("keyd", w);
        checks++;
        if (key_code !== 4'hD) begin errors++; $display("FAIL keyd_code: got %h expected d", key_code); end
        release_all("keyd");
    endtask

    task automatic test_enable_drop();
        int w;
        int p0;
        keys[2*4+0] = 1'b1;
        exp_q.push_back(4'h7);
        wait_pulse("en", w);
        repeat (3) tick();
        en = 1'b0;
        tick();
        checks += 4;
        if (col_n !== 4'b1111) begin errors++; $display("FAIL en_col_n: got %b expected 1111", col_n); end
        if (key_held !== 1'b0) begin errors++; $display("FAIL en_held: got %b expected 0", key_held); end
        if (key_code !== 4'h7) begin errors++; $display("FAIL en_code_kept: got %h expected 7", key_code); end
        if (key_valid !== 1'b0) begin errors++; $display("FAIL en_valid: got %b expected 0", key_valid); end
        keys = 16'h0000;
        repeat (5) tick();
        p0 = pulse_cnt;
        en = 1'b1;
        tick();
        checks += 2;
        if (col_n !== 4'b1110) begin errors++; $display("FAIL en_restart_col: got %b expected 1110", col_n); end
        if (key_code !== 4'h7) begin errors++; $display("FAIL en_restart_code: got %h expected 7", key_code); end
        repeat (20) tick();
        checks++;
        if (pulse_cnt !== p0) begin errors++; $display("FAIL en_no_pulse: pulses=%0d expected %0d", pulse_cnt, p0); end
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b1;
        keys  = 16'h0000;
        test_reset();
        test_steady_press();
        test_bounce_press();
        test_release_bounce();
        test_ghost_then_d();
        test_enable_drop();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected pulses never seen", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
